// File: rtl/ysyx_lsu_bus_sram_resp.sv
// lsu_bus responder: single-port word SRAM serving one AW/W write or AR read at a
// time, answering with B/R exactly LATENCY cycles after the completing handshake.
module ysyx_lsu_bus_sram_resp #(
  parameter int              XLEN      = 32,
  parameter int              MEM_LEN   = 11,
  parameter logic [XLEN-1:0] BASE_ADDR = 'h0f000000,
  parameter int              LATENCY   = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            awvalid,
  output logic            awready,
  input  logic [XLEN-1:0] awaddr,
  input  logic            wvalid,
  output logic            wready,
  input  logic [XLEN-1:0] wdata,
  input  logic [3:0]      wstrb,
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp,
  input  logic            arvalid,
  output logic            arready,
  input  logic [XLEN-1:0] araddr,
  output logic            rvalid,
  input  logic            rready,
  output logic [XLEN-1:0] rdata,
  output logic [1:0]      rresp
);

  typedef enum logic [2:0] {
    IDLE, W_NEED_W, W_NEED_AW, W_WAIT, W_RESP, R_WAIT, R_RESP
  } state_t;

  state_t            state_reg, state_next;
  logic              live_reg;
  logic [3:0]        cnt_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [3:0]        wstrb_reg;
  logic [1:0]        bresp_reg;
  logic [1:0]        rresp_reg;
  logic [XLEN-1:0]   rdata_reg;
  logic [XLEN-1:0]   mem [2**MEM_LEN];

  logic               aw_hs, w_hs, ar_hs;
  logic               hit, commit, sample;
  logic [MEM_LEN-1:0] word_idx;
  logic               unused_addr_lsbs;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign ar_hs  = arvalid & arready;

  // BASE_ADDR is aligned to the array size, so decode is a compare of the upper bits.
  assign hit      = (addr_reg[XLEN-1:MEM_LEN+2] == BASE_ADDR[XLEN-1:MEM_LEN+2]);
  assign word_idx = addr_reg[MEM_LEN+1:2];
  assign unused_addr_lsbs = ^addr_reg[1:0];

  assign commit = (state_reg == W_WAIT) && (cnt_reg == 4'd0);
  assign sample = (state_reg == R_WAIT) && (cnt_reg == 4'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (aw_hs && w_hs)   state_next = W_WAIT;
        else if (aw_hs)      state_next = W_NEED_W;
        else if (w_hs)       state_next = W_NEED_AW;
        else if (ar_hs)      state_next = R_WAIT;
      end
      W_NEED_W:  if (w_hs)  state_next = W_WAIT;
      W_NEED_AW: if (aw_hs) state_next = W_WAIT;
      W_WAIT:    if (cnt_reg == 4'd0) state_next = W_RESP;
      R_WAIT:    if (cnt_reg == 4'd0) state_next = R_RESP;
      W_RESP:    if (bready) state_next = IDLE;
      R_RESP:    if (rready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Readies stay low until the first clock edge after reset is released.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    if (live_reg) begin
      awready = (state_reg == IDLE) || (state_reg == W_NEED_AW);
      wready  = (state_reg == IDLE) || (state_reg == W_NEED_W);
      arready = (state_reg == IDLE) && !awvalid && !wvalid;
    end
    bvalid = (state_reg == W_RESP);
    rvalid = (state_reg == R_RESP);
  end

  assign bresp = bresp_reg;
  assign rresp = rresp_reg;
  assign rdata = rdata_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live_reg  <= 1'b0;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= 4'd0;
      bresp_reg <= 2'b00;
      rresp_reg <= 2'b00;
      rdata_reg <= '0;
    end else begin
      live_reg <= 1'b1;
      if (aw_hs) addr_reg <= awaddr;
      else if (ar_hs) addr_reg <= araddr;
      if (w_hs) begin
        wdata_reg <= wdata;
        wstrb_reg <= wstrb;
      end
      if ((state_next == W_WAIT && state_reg != W_WAIT) ||
          (state_next == R_WAIT && state_reg != R_WAIT)) begin
        cnt_reg <= 4'(LATENCY - 1);
      end else if (cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (commit) bresp_reg <= hit ? 2'b00 : 2'b11;
      if (sample) begin
        rresp_reg <= hit ? 2'b00 : 2'b11;
        rdata_reg <= hit ? mem[word_idx] : '0;
      end
    end
  end

  // Byte-merged write; unstrobed lanes keep their old contents.
  always_ff @(posedge clock) begin
    if (commit && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_reg[i]) mem[word_idx][8*i +: 8] <= wdata_reg[8*i +: 8];
      end
    end
  end

endmodule
